// File: rtl/ble_at_cmd_streamer.sv
// ble_at_cmd_streamer
//   Builds "AT+BLEUARTTX=<payload>\r" or "AT+BLEUARTRX\r" and streams it
//   one byte per cycle on a valid/ready interface toward the UART
//   transmitter that drives the BLE module.
//
// Optional build macro: BLE_AT_HEX_PAYLOAD_EN
//   When defined, each TX payload byte is sent as two uppercase ASCII hex
//   digits (high nibble first). When undefined, payload bytes go out raw.
//
// Parameters
//   PAYLOAD_BYTES : maximum TX payload bytes (>= 1)
//   LEN_W         : width of i_payload_len, 2**LEN_W > PAYLOAD_BYTES
//
// Ports
//   clk             : clock
//   reset           : asynchronous, active-high reset
//   i_cmd_valid     : command request
//   o_cmd_ready     : block can accept a command (IDLE only)
//   i_cmd_sel       : 1 = TX, 2 = RX, other values rejected
//   i_payload       : payload bytes, byte k in [8k+7:8k], byte 0 first
//   i_payload_len   : TX payload length (ignored for RX)
//   o_out_byte      : ASCII output byte
//   o_out_valid     : o_out_byte is valid
//   i_out_ready     : downstream accepts the byte
//   o_out_last      : final byte (CR) marker, qualified by o_out_valid
//   o_done          : one-cycle pulse after the final byte handshake
//   o_err           : one-cycle pulse when a command is rejected
module ble_at_cmd_streamer #(
  parameter int PAYLOAD_BYTES = 16,
  parameter int LEN_W         = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [1:0]                 i_cmd_sel,
  input  logic [8*PAYLOAD_BYTES-1:0] i_payload,
  input  logic [LEN_W-1:0]           i_payload_len,
  output logic [7:0]                 o_out_byte,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_out_last,
  output logic                       o_done,
  output logic                       o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_CR,
    S_DONE,
    S_ERR
  } state_t;

  // Payload slots are padded to the full counter range so the byte mux can
  // be indexed directly by the LEN_W-bit counter.
  localparam int NUM_SLOTS = 2 ** LEN_W;

  state_t                     r_state;
  logic                       r_is_tx;
  logic [8*PAYLOAD_BYTES-1:0] r_payload;
  logic [LEN_W-1:0]           r_len;
  logic [LEN_W-1:0]           r_cnt;
  logic [3:0]                 r_hdr_idx;
`ifdef BLE_AT_HEX_PAYLOAD_EN
  logic                       r_nib;   // 0 = high nibble on the wire, 1 = low
`endif
  logic [7:0]                 r_out_byte;
  logic                       r_out_valid;
  logic                       r_out_last;
  logic                       r_done;
  logic                       r_err;

  logic [7:0]       w_slot [NUM_SLOTS];
  logic             w_accept;
  logic             w_cmd_ok;
  logic             w_fire;
  logic             w_hdr_last;
  logic             w_pay_last;
  logic [LEN_W-1:0] w_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi < PAYLOAD_BYTES) begin : g_used
        assign w_slot[gi] = r_payload[8*gi +: 8];
      end else begin : g_pad
        assign w_slot[gi] = 8'h00;
      end
    end
  endgenerate

  // Header text "AT+BLEUART" followed by "TX=" or "RX".
  function automatic logic [7:0] hdr_char(input logic [3:0] idx, input logic is_tx);
    logic [7:0] c;
    case (idx)
      4'd0:    c = 8'h41;                     // A
      4'd1:    c = 8'h54;                     // T
      4'd2:    c = 8'h2B;                     // +
      4'd3:    c = 8'h42;                     // B
      4'd4:    c = 8'h4C;                     // L
      4'd5:    c = 8'h45;                     // E
      4'd6:    c = 8'h55;                     // U
      4'd7:    c = 8'h41;                     // A
      4'd8:    c = 8'h52;                     // R
      4'd9:    c = 8'h54;                     // T
      4'd10:   c = is_tx ? 8'h54 : 8'h52;     // T / R
      4'd11:   c = 8'h58;                     // X
      4'd12:   c = 8'h3D;                     // =
      default: c = 8'h00;
    endcase
    return c;
  endfunction

`ifdef BLE_AT_HEX_PAYLOAD_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  assign w_accept   = i_cmd_valid && (r_state == S_IDLE);
  assign w_cmd_ok   = (i_cmd_sel == 2'd2) ||
                      ((i_cmd_sel == 2'd1) && (i_payload_len != '0) &&
                       (i_payload_len <= LEN_W'(PAYLOAD_BYTES)));
  assign w_fire     = r_out_valid && i_out_ready;
  assign w_hdr_last = r_is_tx ? (r_hdr_idx == 4'd12) : (r_hdr_idx == 4'd11);
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_pay_last = (r_cnt == (r_len - 1'b1));

  // Outputs are loaded with the byte that goes out next in the same edge
  // that completes the current handshake, so a stalled byte simply holds
  // and ready-high streaming has no bubbles across section boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_tx     <= 1'b0;
      r_payload   <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_hdr_idx   <= 4'd0;
`ifdef BLE_AT_HEX_PAYLOAD_EN
      r_nib       <= 1'b0;
`endif
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_tx   <= (i_cmd_sel == 2'd1);
            r_payload <= i_payload;
            r_len     <= i_payload_len;
            r_cnt     <= '0;
            r_hdr_idx <= 4'd0;
            if (w_cmd_ok) begin
              r_state     <= S_HDR;
              r_out_byte  <= hdr_char(4'd0, 1'b0);
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end

        S_ERR: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end

        S_HDR: begin
          if (w_fire) begin
            if (w_hdr_last) begin
              if (r_is_tx) begin
                r_state <= S_PAY;
                r_cnt   <= '0;
`ifdef BLE_AT_HEX_PAYLOAD_EN
                r_nib      <= 1'b0;
                r_out_byte <= hex_ascii(w_slot[0][7:4]);
`else
                r_out_byte <= w_slot[0];
`endif
              end else begin
                r_state    <= S_CR;
                r_out_byte <= 8'h0D;
                r_out_last <= 1'b1;
              end
            end else begin
              r_hdr_idx  <= r_hdr_idx + 4'd1;
              r_out_byte <= hdr_char(r_hdr_idx + 4'd1, r_is_tx);
            end
          end
        end

        S_PAY: begin
          if (w_fire) begin
`ifdef BLE_AT_HEX_PAYLOAD_EN
            if (!r_nib) begin
              r_nib      <= 1'b1;
              r_out_byte <= hex_ascii(w_slot[r_cnt][3:0]);
            end else if (w_pay_last) begin
              r_state    <= S_CR;
              r_out_byte <= 8'h0D;
              r_out_last <= 1'b1;
            end else begin
              r_nib      <= 1'b0;
              r_cnt      <= w_cnt_next;
              r_out_byte <= hex_ascii(w_slot[w_cnt_next][7:4]);
            end
`else
            if (w_pay_last) begin
              r_state    <= S_CR;
              r_out_byte <= 8'h0D;
              r_out_last <= 1'b1;
            end else begin
              r_cnt      <= w_cnt_next;
              r_out_byte <= w_slot[w_cnt_next];
            end
`endif
          end
        end

        S_CR: begin
          if (w_fire) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_byte  <= 8'h00;
            r_done      <= 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_out_byte  = r_out_byte;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_ble_at_cmd_streamer.sv
// Testbench for ble_at_cmd_streamer: directed and randomized commands,
// checked every cycle against a queue-based model of the expected stream.
module tb_ble_at_cmd_streamer;

  localparam int PB = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_sel;
  logic [8*PB-1:0] i_payload;
  logic [LW-1:0] i_payload_len;
  logic [7:0]    o_out_byte;
  logic          o_out_valid;
  logic          i_out_ready;
  logic          o_out_last;
  logic          o_done;
  logic          o_err;

  ble_at_cmd_streamer #(.PAYLOAD_BYTES(PB), .LEN_W(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_sel     (i_cmd_sel),
    .i_payload     (i_payload),
    .i_payload_len (i_payload_len),
    .o_out_byte    (o_out_byte),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_last    (o_out_last),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  // Written only by the checking process.
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  bit         exp_done = 1'b0;
  bit         exp_err  = 1'b0;
  int         lit_seen = 0;
  int         tmo_seen = 0;

  // Written only by the stimulus process.
  int    lit_seq = 0;
  string lit_exp = "";
  string lit_name = "";
  int    tmo_seq = 0;

  string hdr_txt = "AT+BLEUART";
  string hex_txt = "0123456789ABCDEF";

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic string render(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) begin
      if (q[i] == 8'h0D) s = {s, "<CR>"};
      else s = {s, $sformatf("%c", q[i])};
    end
    return s;
  endfunction

  // Checking process: compares DUT outputs with the model each cycle, then
  // advances the model with the inputs the next rising edge will see.
  initial begin
    bit busy;
    bit nd;
    bit ne;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        chk("rst_out_byte", 32'(o_out_byte), 32'd0);
        chk("rst_out_last", 32'(o_out_last), 32'd0);
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        n_vec++;
        if (render(cap_q) != lit_exp) begin
          n_err++;
          $display("FAIL %s: got \"%s\", expected \"%s\"", lit_name, render(cap_q), lit_exp);
        end
      end
      if (tmo_seq != tmo_seen) begin
        tmo_seen = tmo_seq;
        n_vec++;
        n_err++;
      end
      busy = (exp_q.size() != 0) || exp_done || exp_err;
      chk("cmd_ready", 32'(o_cmd_ready), 32'(!busy));
      chk("out_valid", 32'(o_out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_byte", 32'(o_out_byte), 32'(exp_q[0]));
        chk("out_last", 32'(o_out_last), 32'(exp_q.size() == 1));
      end
      chk("done", 32'(o_done), 32'(exp_done));
      chk("err", 32'(o_err), 32'(exp_err));

      if (!reset) begin
        nd = 1'b0;
        ne = 1'b0;
        if (o_out_valid && i_out_ready) cap_q.push_back(o_out_byte);
        if (exp_q.size() != 0 && i_out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) nd = 1'b1;
        end
        if (!busy && i_cmd_valid) begin
          cap_q.delete();
          if (i_cmd_sel == 2'd2 ||
              (i_cmd_sel == 2'd1 && int'(i_payload_len) >= 1 && int'(i_payload_len) <= PB)) begin
            for (int i = 0; i < hdr_txt.len(); i++) exp_q.push_back(hdr_txt[i]);
            if (i_cmd_sel == 2'd2) begin
              exp_q.push_back(8'h52);
              exp_q.push_back(8'h58);
            end else begin
              exp_q.push_back(8'h54);
              exp_q.push_back(8'h58);
              exp_q.push_back(8'h3D);
              for (int k = 0; k < int'(i_payload_len); k++) begin
                logic [7:0] b;
                b = i_payload[8*k +: 8];
`ifdef BLE_AT_HEX_PAYLOAD_EN
                exp_q.push_back(hex_txt[int'(b[7:4])]);
                exp_q.push_back(hex_txt[int'(b[3:0])]);
`else
                exp_q.push_back(b);
`endif
              end
            end
            exp_q.push_back(8'h0D);
          end else begin
            ne = 1'b1;
          end
        end
        exp_done = nd;
        exp_err  = ne;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] sel, input logic [LW-1:0] len, input logic [8*PB-1:0] pl);
    int w = 0;
    while (!o_cmd_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!o_cmd_ready) begin
      $display("FAIL cmd_ready_timeout @%0t: got 0, expected 1 within 50 cycles", $time);
      tmo_seq++;
    end
    i_cmd_valid   = 1'b1;
    i_cmd_sel     = sel;
    i_payload_len = len;
    i_payload     = pl;
    @(posedge clk); #1;
    i_cmd_valid   = 1'b0;
    i_cmd_sel     = 2'($urandom_range(0, 3));
    i_payload_len = LW'($urandom_range(0, 31));
    i_payload     = {4{$urandom}};
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0; 2: random ready.
  task automatic run_cmd(input int mode, input bit noise);
    int cyc = 0;
    bit fin = 1'b0;
    while (!fin) begin
      if (o_done || o_err) begin
        fin = 1'b1;
      end else if (cyc >= 400) begin
        $display("FAIL run_timeout @%0t: got no done/err, expected one within 400 cycles", $time);
        tmo_seq++;
        fin = 1'b1;
      end else begin
        case (mode)
          0:       i_out_ready = 1'b1;
          1:       i_out_ready = (cyc % 3 == 0);
          default: i_out_ready = 1'($urandom_range(0, 1));
        endcase
        if (noise) begin
          i_cmd_valid   = 1'($urandom_range(0, 1));
          i_cmd_sel     = 2'($urandom_range(0, 3));
          i_payload_len = LW'($urandom_range(0, 31));
          i_payload     = {4{$urandom}};
        end
        cyc++;
        @(posedge clk); #1;
      end
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic expect_lit(input string name, input string s);
    lit_name = name;
    lit_exp  = s;
    lit_seq++;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*PB-1:0] pl;
    reset         = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd_sel     = 2'd0;
    i_payload     = '0;
    i_payload_len = '0;
    i_out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // TX "WIC!" with ready held high.
    pl = '0;
    pl[31:0] = 32'h2143_4957;
    send_cmd(2'd1, 5'd4, pl);
    run_cmd(0, 1'b1);
`ifdef BLE_AT_HEX_PAYLOAD_EN
    expect_lit("tx_wic", "AT+BLEUARTTX=57494321<CR>");
`else
    expect_lit("tx_wic", "AT+BLEUARTTX=WIC!<CR>");
`endif

    // RX with a nonzero length that must be ignored.
    send_cmd(2'd2, 5'd9, pl);
    run_cmd(0, 1'b0);
    expect_lit("rx_len9", "AT+BLEUARTRX<CR>");

    // TX len 2 with stalling ready.
    pl = '0;
    pl[15:0] = 16'h4B4F;
    send_cmd(2'd1, 5'd2, pl);
    run_cmd(1, 1'b0);
`ifdef BLE_AT_HEX_PAYLOAD_EN
    expect_lit("tx_stall", "AT+BLEUARTTX=4F4B<CR>");
`else
    expect_lit("tx_stall", "AT+BLEUARTTX=OK<CR>");
`endif

    // Rejected commands.
    send_cmd(2'd3, 5'd4, pl);
    run_cmd(0, 1'b0);
    send_cmd(2'd0, 5'd4, pl);
    run_cmd(0, 1'b0);
    send_cmd(2'd1, 5'd0, pl);
    run_cmd(0, 1'b0);
    send_cmd(2'd1, 5'd17, pl);
    run_cmd(0, 1'b0);
    send_cmd(2'd1, 5'd16, {4{$urandom}});
    run_cmd(2, 1'b1);

    // Single-byte payload 0x3A.
    pl = '0;
    pl[7:0] = 8'h3A;
    send_cmd(2'd1, 5'd1, pl);
    run_cmd(0, 1'b0);
`ifdef BLE_AT_HEX_PAYLOAD_EN
    expect_lit("tx_3a", "AT+BLEUARTTX=3A<CR>");
`else
    expect_lit("tx_3a", "AT+BLEUARTTX=:<CR>");
`endif

    // Reset in the middle of the payload, then a fresh RX command.
    send_cmd(2'd1, 5'd8, {4{$urandom}});
    i_out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    send_cmd(2'd2, 5'd0, pl);
    run_cmd(0, 1'b0);
    expect_lit("rx_after_reset", "AT+BLEUARTRX<CR>");

    // Randomized commands, back to back, with noise on the command port.
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [1:0] sel;
      r = $urandom_range(0, 15);
      if (r < 8) sel = 2'd1;
      else if (r < 13) sel = 2'd2;
      else sel = 2'($urandom_range(0, 3));
      send_cmd(sel, LW'($urandom_range(0, 20)), {4{$urandom}});
      run_cmd($urandom_range(0, 2), 1'b1);
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ble_at_cmd_streamer.md
# ble_at_cmd_streamer

Parametrised successor to the fixed-width Bluetooth AT encoder. It builds `AT+BLEUARTTX=<payload>\r` or `AT+BLEUARTRX\r` and emits the result one byte per cycle on a valid/ready stream. Payload length is variable up to `PAYLOAD_BYTES`. The block sits between the sensor/packet logic and the UART transmitter that drives the BLE module.

## Interface
- `PAYLOAD_BYTES`, 16: maximum TX payload bytes (≥1).
- `LEN_W`, 5: width of `payload_len`. Must satisfy 2^LEN_W > PAYLOAD_BYTES.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block can accept a command. High only in IDLE.
- `cmd_sel` in 2: 2'd1 = TX, 2'd2 = RX, any other value is invalid.
- `payload` in 8*PAYLOAD_BYTES: payload bytes. Byte k is in [8k+7:8k]; byte 0 is sent first.
- `payload_len` in LEN_W: number of payload bytes for TX. Ignored for RX.
- `out_byte` out 8: ASCII byte.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: downstream accepts the byte.
- `out_last` out 1: marks the final byte (`\r`). Qualified by `out_valid`.
- `done` out 1: one-cycle pulse the cycle after the last byte handshake.
- `err` out 1: one-cycle pulse when a command is rejected.

## Operation
- Command accept: `cmd_valid && cmd_ready`.
  - At accept, the block latches `cmd_sel`, `payload` and `payload_len`. Later input changes have no effect.
- Validity check, performed at accept. A command is invalid if any of these hold:
  - `cmd_sel` is not 1 or 2.
  - TX with `payload_len == 0`.
  - TX with `payload_len > PAYLOAD_BYTES`.
- State machine and transitions:
  - IDLE: accept a valid command → HDR. Accept an invalid command → ERR.
  - ERR: `err` = 1 for one cycle → IDLE. No bytes are emitted.
  - HDR: emits the header through a 4-bit index, from 0 up.
    - The first 10 bytes are `AT+BLEUART`.
    - TX then emits `T`, `X`, `=` (13 bytes total) → PAY.
    - RX then emits `R`, `X` (12 bytes total) → CR.
  - PAY: emits latched payload bytes 0..len-1 using a LEN_W-bit counter → CR.
  - CR: emits 0x0D with `out_last` = 1. On handshake → DONE.
  - DONE: `done` = 1 for one cycle → IDLE.
- Byte advance: the index or counter advances only when `out_valid && out_ready`.
- Hold rule: while `out_valid && !out_ready`, `out_byte`, `out_last` and the state stay stable.
- Total byte count:
  - TX: 14 + len.
  - RX: 13.
- Reset:
  - Reset values: state IDLE, `cmd_ready` = 1, `out_valid` = 0, `out_byte` = 0, `out_last` = 0, `done` = 0, `err` = 0, all counters 0.
  - Reset asserted mid-command aborts it immediately. No `done` or `err` is produced for the aborted command.
- `cmd_valid` outside IDLE is ignored; the command is not queued.

## Timing
- Accept at cycle T: `out_valid` = 1 with `A` at T+1. `cmd_ready` = 0 from T+1.
- With `out_ready` held high, one byte transfers per cycle with no bubbles, including across the HDR→PAY→CR boundaries.
- Last handshake at cycle L: `done` at L+1 and `out_valid` = 0 at L+1. `cmd_ready` = 1 at L+2.
- Back-to-back commands: the minimum gap from the last byte handshake of one command to the next accept is 2 cycles.
- Invalid accept at T: `err` at T+1 and `cmd_ready` = 1 at T+2. `out_valid` stays 0.
- `out_*` outputs are registered. `cmd_ready` is decoded from the registered state.

## Configuration
- `BLE_AT_HEX_PAYLOAD_EN` defined:
  - In PAY, each payload byte is sent as two uppercase ASCII hex digits, high nibble first (0–9 → 0x30–0x39, A–F → 0x41–0x46).
  - The payload section is 2·len bytes, so a TX command totals 14 + 2·len bytes.
  - The byte counter gains a nibble-select bit.
- Not defined:
  - Payload bytes are sent raw. No hex logic is synthesised.

## Test plan
- TX, len 4, payload bytes 0x57 0x49 0x43 0x21, `out_ready` = 1 → 18 bytes `AT+BLEUARTTX=WIC!\r`, no gaps. `out_last` only on byte 18. `done` one cycle later.
- RX (`cmd_sel` = 2), `payload_len` = 9 → 13 bytes `AT+BLEUARTRX\r`. The length is ignored.
- TX, len 2, `out_ready` toggling 1,0,0,1,… → each byte is held stable while stalled. Output sequence is correct, with no duplicated or dropped bytes.
- Invalid commands each give an `err` pulse at T+1, zero `out_valid` cycles, and `cmd_ready` = 1 at T+2:
  - `cmd_sel` = 3.
  - TX len 0.
  - TX len 17 with `PAYLOAD_BYTES` = 16.
- Reset asserted during a PAY byte:
  - `out_valid` = 0 immediately, with no `done`.
  - A fresh RX command after reset then streams correctly.
- With `BLE_AT_HEX_PAYLOAD_EN`: TX, len 1, payload 0x3A → `AT+BLEUARTTX=3A\r`, 16 bytes.
